// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the ALU; results land in HI/LO WIDTH+1 edges after start.
// Operands are reduced to magnitudes up front; signs are reapplied in the single FIX cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               run_last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (run_last) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state_q != IDLE);
        accept   = start && (state_q == IDLE) && ready_q;
        run_last = (cnt_q == CW'(1));
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Datapath
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod      = neg_res_q ? -acc_q : acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        ready_d    = 1'b1;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (accept) begin
                    is_div_d   = op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    dbz_pend_d = op[1] && (b == '0);
                    cnt_d      = CW'(WIDTH);
                    // acc low half holds the multiplier (mul) or the dividend being shifted out (div)
                    opnd_d     = op[1] ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    if (div_diff[WIDTH]) begin
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                done_d = 1'b1;
                dbz_d  = dbz_pend_q;
                if (is_div_q) begin
                    // with a zero divisor the remainder path already reproduces a
                    hi_d = neg_rem_q ? -rem : rem;
                    lo_d = dbz_pend_q ? '1 : (neg_res_q ? -quo : quo);
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int unsigned n_pass;
    int unsigned n_total;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]   up;
        longint signed sp;
        int signed     sx, sy, q, r;
        case (o)
            2'd0: begin
                up = {32'b0, x} * {32'b0, y};
                return {1'b0, up};
            end
            2'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, 64'(sp)};
            end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                sx = $signed(x);
                sy = $signed(y);
                q  = sx / sy;
                r  = sx % sy;
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after an edge; returns #1 after the edge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz,
                          input string nm);
        logic [31:0] ph, pl;
        bit          busy_ok, hold_ok;
        int          k;
        ph = hi;
        pl = lo;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        chk({nm, ".busy_e0"}, 64'(busy), 64'd1);
        chk({nm, ".done_low"}, 64'(done), 64'd0);
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (hi !== ph || lo !== pl) hold_ok = 1'b0;
        end
        chk({nm, ".latency"}, 64'(k), 64'd33);
        chk({nm, ".busy_run"}, 64'(busy_ok), 64'd1);
        chk({nm, ".hold"}, 64'(hold_ok), 64'd1);
        chk({nm, ".busy_done"}, 64'(busy), 64'd0);
        chk({nm, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({nm, ".lo"}, 64'(lo), 64'(exp_lo));
        chk({nm, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        logic [64:0] m;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          k;
        int          seen;

        n_pass = 0;
        n_total = 0;
        rst = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6]  = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{2'd0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[8]  = '{2'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[11] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.dbz", 64'(div_by_zero), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);

        // Start requested right at release: first edge must not accept it, second edge does.
        rst = 1'b1; start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        chk("sync.first_edge_busy", 64'(busy), 64'd0);
        run_op(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "sync_op");

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                   $sformatf("vec%0d", i));
        end

        // Second start and hi_we mid-RUN must be ignored.
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5; hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        k = 0;
        while (k < 40 && !done) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrun.done_seen", 64'(done), 64'd1);
        chk("midrun.hi", 64'(hi), 64'd2);
        chk("midrun.lo", 64'(lo), 64'd14);
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("donecycle_hi_we.hi", 64'(hi), 64'h1234);
        chk("donecycle_hi_we.lo", 64'(lo), 64'd14);
        lo_we = 1'b1; wdata = 32'h55AA;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("idle_lo_we.lo", 64'(lo), 64'h55AA);
        chk("idle_lo_we.hi", 64'(hi), 64'h1234);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done) seen++;
        end
        chk("midrun.no_second_op", 64'(seen), 64'd0);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = pick();
            ry = pick();
            m  = model(ro, rx, ry);
            run_op(ro, rx, ry, m[63:32], m[31:0], m[64], $sformatf("rand%0d_op%0d", i, ro));
        end

        // Reset asserted mid-DIV after a div-by-zero left non-zero state behind.
        run_op(2'd2, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, "pre_reset");
        op = 2'd3; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset.busy", 64'(busy), 64'd0);
        chk("midreset.done", 64'(done), 64'd0);
        chk("midreset.dbz", 64'(div_by_zero), 64'd0);
        chk("midreset.hi", 64'(hi), 64'd0);
        chk("midreset.lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done) seen++;
        end
        chk("postreset.quiet", 64'(seen), 64'd0);
        m = model(2'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, m[63:32], m[31:0], m[64], "postreset_op");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit, parametrised in operand width, that sits beside the single-cycle ALU in the execute stage. It implements MULT, MULTU, DIV and DIVU, producing a 2×WIDTH result into architectural HI/LO registers over a fixed multi-cycle latency. It uses a start/busy/done handshake and a direct HI/LO write path for MTHI/MTLO. Control stalls dependent MFHI/MFLO on `busy`.

## Interface
- `WIDTH`, 32, operand width and width of each of HI and LO; minimum 4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request an operation; sampled only while `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a`, `b`  in  WIDTH  operands (dividend/multiplicand `a`, divisor/multiplier `b`); sampled with `start`.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  write data for `hi_we`/`lo_we`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO hold a new result.
- `div_by_zero`  out  1  last completed operation was a divide with `b`=0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE→RUN on `start`=1.
  - RUN→FIX after exactly WIDTH RUN cycles.
  - FIX→IDLE unconditionally.
- On start:
  - Latch `op`.
  - Signed ops latch |a| and |b|, plus the result signs.
  - Load the step counter with WIDTH.
- RUN, multiply: shift-add of |a|·|b| into a 2W accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- FIX:
  - Multiply: if the signs differ on MULT, the 2W product is negated.
  - Divide, signed: quotient is truncated toward zero and negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Write HI/LO: multiply gives HI = upper W, LO = lower W; divide gives LO = quotient, HI = remainder.
- |MIN| = 2^(W-1) is treated as unsigned W-bit, so no overflow occurs in the magnitude path.
- DIV MIN/−1: LO = MIN, HI = 0, via natural two's-complement wrap. No flag is raised.
- Divide by zero (DIVU and DIV):
  - LO = all ones, HI = `a` as sampled.
  - `div_by_zero`=1.
  - Latency unchanged.
- `div_by_zero` updates at every completion and is cleared by every non-div-by-zero completion.
- `hi_we`/`lo_we`:
  - Write `wdata` at the clock edge when `busy`=0.
  - Ignored when `busy`=1.
  - `start` with `hi_we` in the same cycle: both take effect; operands come from `a`/`b`.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset (`rst`=0, asynchronous): IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; counter 0. An in-flight operation is discarded.
- Reset release is synchronised internally: the first `start` is accepted at the second rising edge after deassertion.
- Let edge E0 be the edge that samples `start`:
  - `busy`=1 from after E0 until after edge E0+WIDTH+1.
  - `hi`/`lo`/`div_by_zero` update at E0+WIDTH+1.
  - `done`=1 for exactly the cycle following E0+WIDTH+1.
- Latency: WIDTH+1 edges (33 for WIDTH=32).
- Back-to-back: `start` in the `done` cycle is accepted (`busy`=0 there), giving a throughput of 1 op per WIDTH+2 cycles.
- HI/LO are stable and readable in every cycle; they change only at completion, on an accepted write, or at reset.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulse exactly 33 edges after the start edge, `busy` high throughout.
- MULT −3 × 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 100 / 0 -> `lo`=0xFFFFFFFF, `hi`=100, `div_by_zero`=1. A following MULTU 2 × 3 -> `lo`=6, `div_by_zero`=0.
- Second `start` and `hi_we` (`wdata`=0x1234) pulsed mid-RUN -> both ignored; only the first result appears. `hi_we` in the `done` cycle -> `hi`=0x1234.
- `rst` low at cycle 10 of a DIV -> all outputs 0 immediately. After release, no `done` until a new `start`, and a new op completes correctly.
